// File: rtl/edge_event_arbiter.sv
// rtl/edge_event_arbiter.sv - per-channel edge detection, pending flags and round-robin event serialiser
// Optional per-event detection timestamps are enabled with EDGE_TSTAMP_EN.
module edge_event_arbiter #(
    parameter int N_CH   = 4,
    parameter int CHAN_W = 2,
    parameter int TS_W   = 16
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic [N_CH-1:0]   sig_in,
    input  logic [N_CH-1:0]   en_in,
    output logic              evt_valid_out,
    input  logic              evt_ready_in,
    output logic [CHAN_W-1:0] evt_chan_out,
    output logic              evt_rise_out,
    output logic [N_CH-1:0]   ovf_out,
    input  logic              ovf_clr_in
`ifdef EDGE_TSTAMP_EN
    ,
    output logic [TS_W-1:0]   evt_ts_out
`endif
);

    if (((1 << CHAN_W) < N_CH) || (TS_W < 1)) begin : g_bad_params
        $error("edge_event_arbiter: CHAN_W too narrow for N_CH or TS_W < 1");
    end

    typedef enum logic {IDLE, PRESENT} state_t;

    state_t            state, state_nxt;
    logic [N_CH-1:0]   sig_r, pend_rise, pend_fall;
    logic [N_CH-1:0]   rise, fall, cand, win_oh;
    logic [N_CH-1:0]   clr_rise, clr_fall, keep_rise, keep_fall, ovf_new;
    logic [CHAN_W-1:0] rr_ptr, ptr_nxt, win, win_hi, win_lo;
    logic              found_hi, found_lo, win_rise, load;

    assign rise = en_in & ~sig_r & sig_in;
    assign fall = en_in & sig_r & ~sig_in;
    assign cand = pend_rise | pend_fall;

    // Two scans: candidates at/after rr_ptr take priority, else the lowest index wraps in.
    always_comb begin
        found_hi = 1'b0;
        found_lo = 1'b0;
        win_hi   = '0;
        win_lo   = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (!found_hi && cand[i] && (i >= int'(rr_ptr))) begin
                found_hi = 1'b1;
                win_hi   = CHAN_W'(i);
            end
            if (!found_lo && cand[i]) begin
                found_lo = 1'b1;
                win_lo   = CHAN_W'(i);
            end
        end
        win = found_hi ? win_hi : win_lo;
        for (int i = 0; i < N_CH; i++) begin
            win_oh[i] = (int'(win) == i);
        end
    end

    assign win_rise  = |(pend_rise & win_oh);
    assign load      = found_lo && ((state == IDLE) || evt_ready_in);
    assign clr_rise  = (load && win_rise)  ? win_oh : '0;
    assign clr_fall  = (load && !win_rise) ? win_oh : '0;
    assign keep_rise = pend_rise & ~clr_rise;
    assign keep_fall = pend_fall & ~clr_fall;
    assign ovf_new   = (rise & keep_rise) | (fall & keep_fall);
    assign ptr_nxt   = (int'(win) == N_CH - 1) ? '0 : win + 1'b1;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (load) state_nxt = PRESENT;
            PRESENT: if (evt_ready_in && !found_lo) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign evt_valid_out = (state == PRESENT);

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state        <= IDLE;
            sig_r        <= '0;
            pend_rise    <= '0;
            pend_fall    <= '0;
            ovf_out      <= '0;
            rr_ptr       <= '0;
            evt_chan_out <= '0;
            evt_rise_out <= 1'b0;
        end else begin
            state     <= state_nxt;
            sig_r     <= sig_in;
            pend_rise <= keep_rise | rise;
            pend_fall <= keep_fall | fall;
            ovf_out   <= (ovf_clr_in ? '0 : ovf_out) | ovf_new;
            if (load) begin
                evt_chan_out <= win;
                evt_rise_out <= win_rise;
                rr_ptr       <= ptr_nxt;
            end
        end
    end

`ifdef EDGE_TSTAMP_EN
    logic [TS_W-1:0] ts_cnt, ts_sel;
    logic [TS_W-1:0] ts_rise [N_CH];
    logic [TS_W-1:0] ts_fall [N_CH];

    always_comb begin
        ts_sel = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (win_oh[i]) ts_sel = win_rise ? ts_rise[i] : ts_fall[i];
        end
    end

    // A stamp is only written when its flag is newly set, so dropped edges leave it intact.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            ts_cnt     <= '0;
            evt_ts_out <= '0;
            for (int i = 0; i < N_CH; i++) begin
                ts_rise[i] <= '0;
                ts_fall[i] <= '0;
            end
        end else begin
            ts_cnt <= ts_cnt + 1'b1;
            if (load) evt_ts_out <= ts_sel;
            for (int i = 0; i < N_CH; i++) begin
                if (rise[i] && !keep_rise[i]) ts_rise[i] <= ts_cnt;
                if (fall[i] && !keep_fall[i]) ts_fall[i] <= ts_cnt;
            end
        end
    end
`endif

endmodule

// File: tb/tb_edge_event_arbiter.sv
// tb/tb_edge_event_arbiter.sv - directed and randomized checks of edge_event_arbiter against an event-level model
module tb_edge_event_arbiter;

    logic       clk_in = 1'b0;
    logic       rst_in = 1'b1;
    logic [3:0] sig_in = '0;
    logic [3:0] en_in = 4'hF;
    logic       evt_ready_in = 1'b1;
    logic       ovf_clr_in = 1'b0;
    logic       evt_valid_out;
    logic [1:0] evt_chan_out;
    logic       evt_rise_out;
    logic [3:0] ovf_out;
`ifdef EDGE_TSTAMP_EN
    logic [15:0] evt_ts_out;
`endif

    int total = 0;
    int bad = 0;

    // Event-level model: per-channel rise/fall flags, pointer and the presented event.
    logic [3:0]  m_prev, m_pr, m_pf, m_ovf;
    int          m_ptr;
    bit          m_valid, m_rise;
    logic [1:0]  m_chan;
    logic [15:0] m_ts, m_tsout;
    logic [15:0] m_tsr [4];
    logic [15:0] m_tsf [4];

    edge_event_arbiter #(.N_CH(4), .CHAN_W(2), .TS_W(16)) dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .sig_in        (sig_in),
        .en_in         (en_in),
        .evt_valid_out (evt_valid_out),
        .evt_ready_in  (evt_ready_in),
        .evt_chan_out  (evt_chan_out),
        .evt_rise_out  (evt_rise_out),
        .ovf_out       (ovf_out),
        .ovf_clr_in    (ovf_clr_in)
`ifdef EDGE_TSTAMP_EN
        ,
        .evt_ts_out    (evt_ts_out)
`endif
    );

    always #5 clk_in = ~clk_in;

    task automatic tick();
        bit         found;
        int         w;
        logic [3:0] nov;
        @(posedge clk_in);
        if (rst_in) begin
            m_prev = '0; m_pr = '0; m_pf = '0; m_ovf = '0; m_ptr = 0;
            m_valid = 0; m_rise = 0; m_chan = '0; m_ts = '0; m_tsout = '0;
            for (int i = 0; i < 4; i++) begin m_tsr[i] = '0; m_tsf[i] = '0; end
        end else begin
            if (!m_valid || evt_ready_in) begin
                found = 0;
                w = 0;
                for (int k = 0; k < 4; k++) begin
                    if (!found && (m_pr[(m_ptr + k) % 4] || m_pf[(m_ptr + k) % 4])) begin
                        found = 1;
                        w = (m_ptr + k) % 4;
                    end
                end
                if (found) begin
                    m_valid = 1;
                    m_chan = 2'(w);
                    m_rise = m_pr[w];
                    if (m_pr[w]) begin m_pr[w] = 1'b0; m_tsout = m_tsr[w]; end
                    else begin m_pf[w] = 1'b0; m_tsout = m_tsf[w]; end
                    m_ptr = (w + 1) % 4;
                end else begin
                    m_valid = 0;
                end
            end
            nov = '0;
            for (int i = 0; i < 4; i++) begin
                if (en_in[i] && !m_prev[i] && sig_in[i]) begin
                    if (m_pr[i]) nov[i] = 1'b1;
                    else begin m_pr[i] = 1'b1; m_tsr[i] = m_ts; end
                end
                if (en_in[i] && m_prev[i] && !sig_in[i]) begin
                    if (m_pf[i]) nov[i] = 1'b1;
                    else begin m_pf[i] = 1'b1; m_tsf[i] = m_ts; end
                end
            end
            m_ovf = (ovf_clr_in ? 4'b0 : m_ovf) | nov;
            m_prev = sig_in;
            m_ts = m_ts + 16'd1;
        end
        #1;
    endtask

    task automatic do_reset();
        sig_in = '0; en_in = 4'hF; evt_ready_in = 1'b1; ovf_clr_in = 1'b0;
        rst_in = 1'b1;
        tick();
        rst_in = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        sig_in = '0; rst_in = 1'b1;
        tick();
        tick();
        total++; if (evt_valid_out !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", evt_valid_out); end
        total++; if (ovf_out !== 4'b0) begin bad++; $display("FAIL reset_ovf got=%b want=0000", ovf_out); end
        total++; if (evt_chan_out !== 2'd0 || evt_rise_out !== 1'b0) begin bad++; $display("FAIL reset_evt got chan=%0d rise=%b want 0/0", evt_chan_out, evt_rise_out); end
        rst_in = 1'b0;
        tick();
    endtask

    task automatic test_latency();
        do_reset();
        tick();
        sig_in[2] = 1'b1;
        tick();
        total++; if (evt_valid_out !== 1'b0) begin bad++; $display("FAIL lat_early got=%b want=0", evt_valid_out); end
        tick();
        total++; if (evt_valid_out !== 1'b1 || evt_chan_out !== 2'd2 || evt_rise_out !== 1'b1) begin
            bad++; $display("FAIL lat_event got v=%b ch=%0d r=%b want 1/2/1", evt_valid_out, evt_chan_out, evt_rise_out); end
        tick();
        total++; if (evt_valid_out !== 1'b0) begin bad++; $display("FAIL lat_one_cycle got=%b want=0", evt_valid_out); end
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_ch [3];
        exp_ch = '{2'd0, 2'd1, 2'd3};
        do_reset();
        sig_in = 4'b1011;
        tick();
        for (int j = 0; j < 3; j++) begin
            tick();
            total++; if (evt_valid_out !== 1'b1 || evt_chan_out !== exp_ch[j] || evt_rise_out !== 1'b1) begin
                bad++; $display("FAIL rr_rise[%0d] got v=%b ch=%0d r=%b want 1/%0d/1", j, evt_valid_out, evt_chan_out, evt_rise_out, exp_ch[j]); end
        end
        tick();
        total++; if (evt_valid_out !== 1'b0) begin bad++; $display("FAIL rr_idle got=%b want=0", evt_valid_out); end
        sig_in = 4'b0000;
        tick();
        for (int j = 0; j < 3; j++) begin
            tick();
            total++; if (evt_valid_out !== 1'b1 || evt_chan_out !== exp_ch[j] || evt_rise_out !== 1'b0) begin
                bad++; $display("FAIL rr_fall[%0d] got v=%b ch=%0d r=%b want 1/%0d/0", j, evt_valid_out, evt_chan_out, evt_rise_out, exp_ch[j]); end
        end
    endtask

    task automatic test_overflow_and_clear();
        do_reset();
        evt_ready_in = 1'b0;
        sig_in[1] = 1'b1; tick();
        sig_in[1] = 1'b0; tick();
        sig_in[1] = 1'b1; tick();
        sig_in[1] = 1'b0; tick();
        total++; if (ovf_out !== 4'b0010) begin bad++; $display("FAIL ovf_set got=%b want=0010", ovf_out); end
        total++; if (evt_valid_out !== 1'b1 || evt_chan_out !== 2'd1 || evt_rise_out !== 1'b1) begin
            bad++; $display("FAIL ovf_held got v=%b ch=%0d r=%b want 1/1/1", evt_valid_out, evt_chan_out, evt_rise_out); end
        evt_ready_in = 1'b1;
        tick();
        total++; if (evt_valid_out !== 1'b1 || evt_chan_out !== 2'd1 || evt_rise_out !== 1'b1) begin
            bad++; $display("FAIL ovf_next_rise got v=%b ch=%0d r=%b want 1/1/1", evt_valid_out, evt_chan_out, evt_rise_out); end
        tick();
        total++; if (evt_valid_out !== 1'b1 || evt_chan_out !== 2'd1 || evt_rise_out !== 1'b0) begin
            bad++; $display("FAIL ovf_next_fall got v=%b ch=%0d r=%b want 1/1/0", evt_valid_out, evt_chan_out, evt_rise_out); end
        tick();
        total++; if (evt_valid_out !== 1'b0) begin bad++; $display("FAIL ovf_drained got=%b want=0", evt_valid_out); end
        evt_ready_in = 1'b0;
        sig_in[3] = 1'b1; tick();
        sig_in[3] = 1'b0; tick();
        sig_in[3] = 1'b1; tick();
        total++; if (ovf_out !== 4'b0010) begin bad++; $display("FAIL clr_before got=%b want=0010", ovf_out); end
        sig_in[3] = 1'b0; ovf_clr_in = 1'b1; tick();
        ovf_clr_in = 1'b0;
        total++; if (ovf_out !== 4'b1000) begin bad++; $display("FAIL clr_vs_new got=%b want=1000", ovf_out); end
        evt_ready_in = 1'b1;
    endtask

    task automatic test_stall();
        do_reset();
        evt_ready_in = 1'b0;
        sig_in[0] = 1'b1; tick();
        tick();
        sig_in[2] = 1'b1;
        for (int j = 0; j < 5; j++) begin
            tick();
            total++; if (evt_valid_out !== 1'b1 || evt_chan_out !== 2'd0 || evt_rise_out !== 1'b1) begin
                bad++; $display("FAIL stall_hold[%0d] got v=%b ch=%0d r=%b want 1/0/1", j, evt_valid_out, evt_chan_out, evt_rise_out); end
        end
        evt_ready_in = 1'b1;
        tick();
        total++; if (evt_valid_out !== 1'b1 || evt_chan_out !== 2'd2 || evt_rise_out !== 1'b1) begin
            bad++; $display("FAIL stall_next got v=%b ch=%0d r=%b want 1/2/1", evt_valid_out, evt_chan_out, evt_rise_out); end
        tick();
        total++; if (evt_valid_out !== 1'b0) begin bad++; $display("FAIL stall_idle got=%b want=0", evt_valid_out); end
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < 4; i++) if ($urandom_range(0, 3) == 0) sig_in[i] = ~sig_in[i];
            en_in = ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'hF;
            evt_ready_in = ($urandom_range(0, 9) < 6);
            ovf_clr_in = ($urandom_range(0, 19) == 0);
            rst_in = ($urandom_range(0, 299) == 0);
            tick();
            total++; if (evt_valid_out !== m_valid) begin bad++; $display("FAIL rnd_valid n=%0d got=%b want=%b", n, evt_valid_out, m_valid); end
            total++; if (ovf_out !== m_ovf) begin bad++; $display("FAIL rnd_ovf n=%0d got=%b want=%b", n, ovf_out, m_ovf); end
            if (m_valid) begin
                total++; if (evt_chan_out !== m_chan || evt_rise_out !== m_rise) begin
                    bad++; $display("FAIL rnd_evt n=%0d got ch=%0d r=%b want ch=%0d r=%b", n, evt_chan_out, evt_rise_out, m_chan, m_rise); end
`ifdef EDGE_TSTAMP_EN
                total++; if (evt_ts_out !== m_tsout) begin bad++; $display("FAIL rnd_ts n=%0d got=%h want=%h", n, evt_ts_out, m_tsout); end
`endif
            end
        end
        rst_in = 1'b0; ovf_clr_in = 1'b0; en_in = 4'hF; evt_ready_in = 1'b1;
    endtask

`ifdef EDGE_TSTAMP_EN
    task automatic test_tstamp();
        int guard;
        do_reset();
        guard = 0;
        while (m_ts != 16'hFFFE && guard < 70000) begin tick(); guard++; end
        sig_in[0] = 1'b1; tick();
        tick();
        total++; if (evt_valid_out !== 1'b1 || evt_chan_out !== 2'd0 || evt_ts_out !== 16'hFFFE) begin
            bad++; $display("FAIL ts_wrap_hi got v=%b ch=%0d ts=%h want 1/0/fffe", evt_valid_out, evt_chan_out, evt_ts_out); end
        guard = 0;
        while (m_ts != 16'h0001 && guard < 10) begin tick(); guard++; end
        sig_in[1] = 1'b1; tick();
        tick();
        total++; if (evt_valid_out !== 1'b1 || evt_chan_out !== 2'd1 || evt_ts_out !== 16'h0001) begin
            bad++; $display("FAIL ts_wrap_lo got v=%b ch=%0d ts=%h want 1/1/0001", evt_valid_out, evt_chan_out, evt_ts_out); end
    endtask
`endif

    initial begin
        test_reset();
        test_latency();
        test_round_robin();
        test_overflow_and_clear();
        test_stall();
`ifdef EDGE_TSTAMP_EN
        test_tstamp();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
